// File: rtl/report_pkg.sv
// Shared constants and record layout for the cluster-4 report collector.
// The collector top is configured by the REPORT_COLLECTOR_STAMP_EN macro.
package report_pkg;

    // Default geometry of the report interface and record buffer.
    localparam int NUM_REPORTS_DEF = 28;
    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int STAMP_W_DEF     = 16;

    // Per-automaton bit offsets inside report_vec (automaton-major).
    localparam int LTL0_BASE = 0;
    localparam int LTL1_BASE = 4;
    localparam int LTL2_BASE = 8;
    localparam int LTL3_BASE = 12;
    localparam int LTL4_BASE = 16;
    localparam int LTL5_BASE = 20;
    localparam int LTL6_BASE = 24;

    // Position of each report output within an automaton's 4-bit group.
    localparam int OUT_4  = 0;
    localparam int OUT_6  = 1;
    localparam int OUT_9  = 2;
    localparam int OUT_11 = 3;

    // One buffered record: run-cycle stamp above the report bits.
    typedef struct packed {
        logic [STAMP_W_DEF-1:0]     stamp;
        logic [NUM_REPORTS_DEF-1:0] vector;
    } report_rec_t;

    // Bit index of report output 'idx' of automaton 'ltl'.
    function automatic int report_bit(input int ltl, input int idx);
        return 4 * ltl + idx;
    endfunction

endpackage

// File: rtl/report_fifo.sv
// Synchronous first-word-fall-through FIFO. rdata shows the head entry
// whenever the FIFO is not empty and reads as zero while empty.
module report_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot this edge, so a push into a full FIFO still fits.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until covered by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/report_collector_c4.sv
// Turns the cluster-4 automata report wires into buffered report records.
// Build option: REPORT_COLLECTOR_STAMP_EN adds the run-cycle stamp counter
// and stores a stamp with every record; otherwise rec_stamp is tied to 0.
//
// Stream handshake: rec_valid high means rec_vector/rec_stamp hold a record
// and stay stable until it is taken; a record is taken on a clk edge where
// rec_valid && rec_ready; rec_ready while rec_valid is low has no effect.
module report_collector_c4
    import report_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int STAMP_W     = STAMP_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [NUM_REPORTS-1:0] report_vec,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [NUM_REPORTS-1:0] rec_vector,
    output logic [STAMP_W-1:0]     rec_stamp,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

`ifdef REPORT_COLLECTOR_STAMP_EN
    localparam int ENTRY_W = NUM_REPORTS + STAMP_W;
`else
    localparam int ENTRY_W = NUM_REPORTS;
`endif

    logic               push_req;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    assign push_req  = run && (report_vec != '0);
    assign rec_valid = !fifo_empty;
    assign pop       = rec_valid && rec_ready;
    // A full buffer only rejects the push when nothing leaves on the same edge.
    assign drop      = push_req && fifo_full && !pop;

`ifdef REPORT_COLLECTOR_STAMP_EN
    logic [STAMP_W-1:0] stamp_q;

    // Run-cycle counter; the pushed stamp is the value before this increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q <= '0;
        end else if (run) begin
            stamp_q <= stamp_q + {{(STAMP_W-1){1'b0}}, 1'b1};
        end
    end

    assign wdata      = {stamp_q, report_vec};
    assign rec_stamp  = rdata[ENTRY_W-1 -: STAMP_W];
    assign rec_vector = rdata[NUM_REPORTS-1:0];
`else
    assign wdata      = report_vec;
    assign rec_stamp  = '0;
    assign rec_vector = rdata;
`endif

    report_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Overflow bookkeeping: sticky flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_report_collector_c4.sv
// Self-checking bench for report_collector_c4 (either build of
// REPORT_COLLECTOR_STAMP_EN). A queue-based reference model tracks the
// expected buffer contents, stamp counter and drop statistics.
module tb_report_collector_c4;

    localparam int NR    = 28;
    localparam int SW    = 16;
    localparam int DEPTH = 8;
    localparam int W     = NR + SW;
`ifdef REPORT_COLLECTOR_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [NR-1:0] report_vec = '0;
    logic          rec_ready = 1'b0;
    logic          rec_valid;
    logic [NR-1:0] rec_vector;
    logic [SW-1:0] rec_stamp;
    logic          overflow;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    report_collector_c4 dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .report_vec (report_vec),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_vector (rec_vector),
        .rec_stamp  (rec_stamp),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] m_stamp = '0;
    int            m_drops = 0;
    bit            m_ovf = 1'b0;
    int            total_cnt = 0;
    int            pass_cnt = 0;

    function automatic logic [SW-1:0] exp_stamp(input int s);
        return STAMP_EN ? SW'(s) : '0;
    endfunction

    // Model: records enter in order, leave when taken, drop when no room.
    always @(posedge clk) begin
        bit pop_now;
        bit push_now;
        if (reset) begin
            exp_q.delete();
            m_stamp = '0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            pop_now  = (exp_q.size() > 0) && rec_ready;
            push_now = run && (report_vec != '0);
            if (pop_now) void'(exp_q.pop_front());
            if (push_now) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back({(STAMP_EN ? m_stamp : SW'(0)), report_vec});
                end else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1'b1;
                end
            end
            if (run) m_stamp = m_stamp + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("valid", 64'(rec_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("vector", 64'(rec_vector), 64'(exp_q[0][NR-1:0]));
            chk("stamp", 64'(rec_stamp), 64'(exp_q[0][W-1 -: SW]));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic [NR-1:0] v, input logic rdy);
        run        = r;
        report_vec = v;
        rec_ready  = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [NR-1:0] rnd_vec();
        return NR'($urandom_range(1, 32'h0FFF_FFFF));
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_vector", 64'(rec_vector), 64'd0);
        chk("rst_stamp", 64'(rec_stamp), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);

        // Single record at stamp 5, taken immediately.
        drive(1'b1, '0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b1, NR'(1), 1'b1);
        tick();
        chk("s1_valid", 64'(rec_valid), 64'd1);
        chk("s1_vector", 64'(rec_vector), 64'd1);
        chk("s1_stamp", 64'(rec_stamp), 64'(exp_stamp(5)));
        drive(1'b1, '0, 1'b1);
        tick();
        chk("s1_gone", 64'(rec_valid), 64'd0);

        // Fill 8, drop the 9th, then drain in order.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, NR'(i), 1'b0);
            tick();
        end
        chk("s2_overflow", 64'(overflow), 64'd1);
        chk("s2_drops", 64'(drop_count), 64'd1);
        drive(1'b0, '0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            chk("s2_drain_vec", 64'(rec_vector), 64'(i));
            chk("s2_drain_stamp", 64'(rec_stamp), 64'(exp_stamp(i - 1)));
            tick();
        end
        chk("s2_empty", 64'(rec_valid), 64'd0);

        // Full buffer with push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, NR'(8'h10 + i), 1'b0);
            tick();
        end
        drive(1'b1, NR'(8'hAA), 1'b1);
        tick();
        chk("s3_no_drop", 64'(drop_count), 64'd0);
        chk("s3_no_ovf", 64'(overflow), 64'd0);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("s3_order", 64'(rec_vector), (i < 7) ? 64'(8'h11 + i) : 64'hAA);
            tick();
        end
        chk("s3_empty", 64'(rec_valid), 64'd0);

        // run toggling 1,0,0,1 with a constant non-zero report.
        do_reset();
        drive(1'b1, NR'(3), 1'b0); tick();
        drive(1'b0, NR'(3), 1'b0); tick();
        drive(1'b0, NR'(3), 1'b0); tick();
        drive(1'b1, NR'(3), 1'b0); tick();
        drive(1'b0, '0, 1'b0);
        chk("s4_first_stamp", 64'(rec_stamp), 64'(exp_stamp(0)));
        drive(1'b0, '0, 1'b1); tick();
        chk("s4_second_stamp", 64'(rec_stamp), 64'(exp_stamp(1)));
        chk("s4_second_vec", 64'(rec_vector), 64'd3);
        tick();
        chk("s4_only_two", 64'(rec_valid), 64'd0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 308; i++) begin
            drive(1'b1, rnd_vec(), 1'b0);
            tick();
        end
        chk("s5_sat", 64'(drop_count), 64'd255);
        chk("s5_ovf", 64'(overflow), 64'd1);

        // Reset with entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rnd_vec(), 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        chk("s6_valid", 64'(rec_valid), 64'd0);
        chk("s6_drops", 64'(drop_count), 64'd0);
        chk("s6_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        drive(1'b1, NR'(5), 1'b0);
        tick();
        chk("s6_stamp0", 64'(rec_stamp), 64'(exp_stamp(0)));
        chk("s6_vec", 64'(rec_vector), 64'd5);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 3) ? NR'(0) : rnd_vec(),
                  ($urandom_range(0, 9) < 5));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
